// File: rtl/apb_cfg_master.sv
// APB3 initiator: single-beat register commands in, one response out.
// Drives SETUP/ACCESS, waits on pready, captures read data, aborts on timeout.
module apb_cfg_master #(
  parameter int unsigned RDATA_LAT = 1,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic        pready,
  input  logic [31:0] prdata
);

  localparam int unsigned CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TL =
    (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = TL[CW-1:0];
  localparam logic [CW-1:0] TO_MAX  = TIMEOUT[CW-1:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RDWAIT,
    S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic          rdy_q, rdy_d;
  logic          pwrite_q, pwrite_d;
  logic [31:0]   paddr_q, paddr_d;
  logic [31:0]   pwdata_q, pwdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [CW-1:0] wait_q, wait_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rdy_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      wait_q   <= wait_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    wait_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && rdy_q) begin
          state_d  = S_SETUP;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_write ? cmd_wdata : '0;
          rdata_d  = '0;
          err_d    = 1'b0;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (pready) begin
          if (pwrite_q) begin
            state_d = S_RESP;
          end else if (RDATA_LAT == 0) begin
            state_d = S_RESP;
            rdata_d = prdata;
          end else begin
            state_d = S_RDWAIT;
          end
        end else begin
          wait_d = (wait_q < TO_MAX) ? wait_q + CW'(1) : wait_q;
          // wait_q counts prior stalls, so TO_LAST marks the final allowed cycle
          if (TIMEOUT != 0 && wait_q == TO_LAST) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      S_RDWAIT: begin
        state_d = S_RESP;
        rdata_d = prdata;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    rdy_d = (state_d == S_IDLE);
  end

  assign cmd_ready = rdy_q;
  assign psel      = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign penable   = (state_q == S_ACCESS);
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_cfg_master.sv
// Directed bench for apb_cfg_master: vector table plus reset corner cases.
// The slave model registers prdata one cycle after the completing ACCESS.
module tb_apb_cfg_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic        pready = 1'b1;
  logic [31:0] prdata = '0;

  logic [31:0] slave_data = '0;
  int checks = 0;
  int failures = 0;

  apb_cfg_master #(.RDATA_LAT(1), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (psel && penable && pready && !pwrite)
      prdata <= slave_data;
    else
      prdata <= 32'hBAD0_BAD0;
  end

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] sdat;
    int          nwait;
    int          hold;
    int          lat;
    logic [31:0] rd;
    logic        err;
    int          acc;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, output int lat,
                     output logic [31:0] rd, output logic er,
                     output int acc, output int viol);
    int n;
    int cyc;
    int stall;
    viol = 0;
    acc = 0;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) viol++;
    slave_data = v.sdat;
    rsp_ready = (v.hold == 0);
    pready = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = v.w;
    cmd_addr = v.a;
    cmd_wdata = v.d;
    stall = v.nwait;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr = 32'hFFFF_FFFF;
    cmd_wdata = 32'h1357_9BDF;
    cyc = 1;
    while (!rsp_valid && cyc < 100) begin
      if (cyc == 1 && !(psel && !penable)) viol++;
      if (penable && !psel) viol++;
      if (cmd_ready) viol++;
      if (psel && (paddr !== v.a || pwrite !== v.w ||
                   pwdata !== (v.w ? v.d : 32'h0)))
        viol++;
      if (psel && penable) begin
        acc++;
        if (stall > 0) begin
          pready = 1'b0;
          stall--;
        end else begin
          pready = 1'b1;
        end
      end else begin
        pready = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    pready = 1'b1;
    lat = rsp_valid ? cyc : -1;
    rd = rsp_rdata;
    er = rsp_err;
    for (int i = 0; i < v.hold; i++) begin
      if (!rsp_valid || rsp_rdata !== rd || rsp_err !== er ||
          cmd_ready || psel)
        viol++;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    if (!cmd_ready || rsp_valid) viol++;
  endtask

  initial begin
    int lat, acc, viol;
    logic [31:0] rd;
    logic er;

    vt[0]  = '{1'b1, 32'h04, 32'h3,        32'h0,    0,    0, 3,  32'h0,    1'b0, 1};
    vt[1]  = '{1'b0, 32'h00, 32'h0,        32'h1B2,  0,    0, 4,  32'h1B2,  1'b0, 1};
    vt[2]  = '{1'b1, 32'h08, 32'hA5A5,     32'h0,    3,    0, 6,  32'h0,    1'b0, 4};
    vt[3]  = '{1'b0, 32'h0C, 32'h77,       32'hCAFE, 2,    0, 6,  32'hCAFE, 1'b0, 3};
    vt[4]  = '{1'b1, 32'h10, 32'h55,       32'h0,    1000, 0, 18, 32'h0,    1'b1, 16};
    vt[5]  = '{1'b0, 32'h14, 32'h0,        32'h55,   1000, 0, 18, 32'h0,    1'b1, 16};
    vt[6]  = '{1'b1, 32'h04, 32'h7,        32'h0,    0,    0, 3,  32'h0,    1'b0, 1};
    vt[7]  = '{1'b1, 32'h18, 32'h99,       32'h0,    15,   0, 18, 32'h0,    1'b0, 16};
    vt[8]  = '{1'b0, 32'h1C, 32'h0,        32'h1234, 15,   0, 19, 32'h1234, 1'b0, 16};
    vt[9]  = '{1'b0, 32'h20, 32'h0,        32'hABCD, 0,    5, 4,  32'hABCD, 1'b0, 1};
    vt[10] = '{1'b1, 32'h24, 32'hFFFFFFFF, 32'h0,    0,    5, 3,  32'h0,    1'b0, 1};

    repeat (3) @(negedge clk);
    chk("reset_outputs",
        64'({psel, penable, pwrite, cmd_ready, rsp_valid, rsp_err,
             |rsp_rdata, |paddr, |pwdata}), 64'h0);
    rst_n = 1'b1;
    chk("ready_at_release", 64'(cmd_ready), 64'h0);
    @(negedge clk);
    chk("ready_after_release", 64'(cmd_ready), 64'h1);

    for (int i = 0; i < 11; i++) begin
      run(vt[i], lat, rd, er, acc, viol);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vt[i].lat));
      chk($sformatf("v%0d_rdata", i), 64'(rd), 64'(vt[i].rd));
      chk($sformatf("v%0d_err", i), 64'(er), 64'(vt[i].err));
      chk($sformatf("v%0d_access_cycles", i), 64'(acc), 64'(vt[i].acc));
      chk($sformatf("v%0d_protocol", i), 64'(viol), 64'h0);
    end

    // reset in the middle of a stalled read
    slave_data = 32'h600D;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 32'h2C;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_setup", 64'({psel, penable}), 64'h2);
    pready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_access", 64'({psel, penable}), 64'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs",
        64'({psel, penable, pwrite, cmd_ready, rsp_valid, rsp_err,
             |rsp_rdata, |paddr, |pwdata}), 64'h0);
    @(negedge clk);
    pready = 1'b1;
    rst_n = 1'b1;
    chk("mid_ready_at_release", 64'(cmd_ready), 64'h0);
    @(negedge clk);
    chk("mid_ready_after", 64'({cmd_ready, rsp_valid, psel}), 64'h4);
    repeat (3) @(negedge clk);
    chk("mid_no_response", 64'({rsp_valid, psel}), 64'h0);

    run(vt[1], lat, rd, er, acc, viol);
    chk("post_reset_latency", 64'(lat), 64'(vt[1].lat));
    chk("post_reset_rdata", 64'(rd), 64'(vt[1].rd));
    chk("post_reset_protocol", 64'(viol), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
